// File: rtl/seg7_to_bcd_scanner_if.sv
// Output-side frame handshake between seg7_to_bcd_scanner and its consumer.
// The scanner drives the frame and flags; the consumer drives out_ready.
interface seg7_to_bcd_scanner_if #(
    parameter int DIGITS = 4
);
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [DIGITS-1:0]     out_err;
    logic                  overrun;

    modport master (
        output out_valid,
        output out_bcd,
        output out_err,
        output overrun,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_bcd,
        input  out_err,
        input  overrun,
        output out_ready
    );
endinterface

// File: rtl/seg7_to_bcd_scanner.sv
// Recovers BCD digits from a multiplexed active-low 7-segment display bus.
// Each strobed digit must hold steady for STABLE_CYCLES samples before it is
// captured; a full set of captured digits is handed out as one frame over a
// valid/ready handshake. Frames completing while one is still pending are
// dropped and flagged on the sticky overrun output.
// Optional build macro SEG7_BLANK_EN: when defined, the all-segments-off
// pattern decodes to a valid blank digit (4'hA, no error).
module seg7_to_bcd_scanner #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg_n,
    input  logic [DIGITS-1:0]    digit_en,
    seg7_to_bcd_scanner_if.master bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW:0] CAP_AT  = (CW + 1)'(STABLE_CYCLES - 1);
    localparam logic [CW:0] CNT_MAX = (CW + 1)'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic [CW:0]         cnt_inc;
    logic                capture;

    logic [6:0]          seg_q;
    logic [6:0]          seg_p;
    logic [DIGITS-1:0]   en_q;
    logic [DIGITS-1:0]   en_p;
    logic                en_onehot;
    logic                en_same;
    logic                all_same;

    logic [3:0]          dec_bcd;
    logic                dec_err;

    logic [DIGITS-1:0]   mask;
    logic [4*DIGITS-1:0] frame_bcd;
    logic [DIGITS-1:0]   frame_err;

    logic                valid_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [DIGITS-1:0]   err_q;
    logic                overrun_q;

    assign bus.out_valid = valid_q;
    assign bus.out_bcd   = bcd_q;
    assign bus.out_err   = err_q;
    assign bus.overrun   = overrun_q;

    assign en_onehot = (en_q != '0) && ((en_q & (en_q - DIGITS'(1))) == '0);
    assign en_same   = (en_q == en_p);
    assign all_same  = en_same && (seg_q == seg_p);
    assign cnt_inc   = {1'b0, cnt} + (CW + 1)'(1);

    // Register the pins once, and keep the previous sample for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            seg_p <= '0;
            en_q  <= '0;
            en_p  <= '0;
        end else begin
            seg_q <= seg_n;
            seg_p <= seg_q;
            en_q  <= digit_en;
            en_p  <= en_q;
        end
    end

    // Segment pattern to BCD digit, with invalid-pattern flag.
    always_comb begin
        dec_bcd = 4'hF;
        dec_err = 1'b1;
        case (seg_q)
            7'b0000001: begin dec_bcd = 4'd0; dec_err = 1'b0; end
            7'b1001111: begin dec_bcd = 4'd1; dec_err = 1'b0; end
            7'b0010010: begin dec_bcd = 4'd2; dec_err = 1'b0; end
            7'b0000110: begin dec_bcd = 4'd3; dec_err = 1'b0; end
            7'b1001100: begin dec_bcd = 4'd4; dec_err = 1'b0; end
            7'b0100100: begin dec_bcd = 4'd5; dec_err = 1'b0; end
            7'b0100000: begin dec_bcd = 4'd6; dec_err = 1'b0; end
            7'b0001111: begin dec_bcd = 4'd7; dec_err = 1'b0; end
            7'b0000000: begin dec_bcd = 4'd8; dec_err = 1'b0; end
            7'b0000100: begin dec_bcd = 4'd9; dec_err = 1'b0; end
`ifdef SEG7_BLANK_EN
            7'b1111111: begin dec_bcd = 4'hA; dec_err = 1'b0; end
`else
            7'b1111111: begin dec_bcd = 4'hF; dec_err = 1'b1; end
`endif
            default:    begin dec_bcd = 4'hF; dec_err = 1'b1; end
        endcase
    end

    // Stability FSM state and counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: count identical samples and capture once the strobe has settled.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (en_onehot) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (!en_onehot) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (!all_same) begin
                    cnt_nxt = '0;
                end else if (cnt_inc >= CAP_AT) begin
                    // Capture on the increment that reaches STABLE_CYCLES-1.
                    capture   = 1'b1;
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else if (cnt_inc <= CNT_MAX) begin
                    cnt_nxt = cnt_inc[CW-1:0];
                end
            end
            HOLD: begin
                if (!en_same) begin
                    cnt_nxt   = '0;
                    state_nxt = en_onehot ? SETTLE : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Digit slots and capture mask; a full mask is consumed the cycle after the last capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask      <= '0;
            frame_bcd <= '0;
            frame_err <= '0;
        end else begin
            if (capture) begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (en_q[i]) begin
                        frame_bcd[4*i +: 4] <= dec_bcd;
                        frame_err[i]        <= dec_err;
                    end
                end
            end
            // A capture always lands in HOLD, so clearing and setting never collide.
            if (mask == '1) begin
                mask <= '0;
            end else if (capture) begin
                mask <= mask | en_q;
            end
        end
    end

    // Output frame register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            bcd_q     <= '0;
            err_q     <= '0;
            overrun_q <= 1'b0;
        end else if (mask == '1) begin
            if (!valid_q || bus.out_ready) begin
                valid_q <= 1'b1;
                bcd_q   <= frame_bcd;
                err_q   <= frame_err;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: doc/seg7_to_bcd_scanner.md
Name: seg7_to_bcd_scanner

Overview:
- Reads a multiplexed, active-low 7-segment display bus and recovers the BCD digit shown on each digit position.
- Inverse of the team's BCD-to-7-segment encoder. Sits on the display pins, beside the display driver, for self-check and loopback test.
- Waits for each digit strobe to be stable, decodes its segment pattern, and assembles the digits into a frame.
- Hands each frame out over a valid/ready handshake.

Parameters:
- DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive identical samples needed before a digit is captured (>=1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- seg_n  input  7  segment lines, active-low (0 = lit); bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- digit_en  input  DIGITS  digit strobe, active-high, one-hot when valid.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts frame.
- out_bcd  output  4*DIGITS  decoded frame; digit i at bits [4i+3:4i].
- out_err  output  DIGITS  per-digit invalid-pattern flag for the presented frame.
- overrun  output  1  sticky; a completed frame was dropped.

Behaviour:
- Reset (async, rst_n=0) clears all state:
  - out_valid=0, out_bcd=0, out_err=0, overrun=0.
  - Capture mask = 0, stability counter = 0, FSM = IDLE.
- Inputs are registered once before use. All latency figures below count from the registered sample.
- Decode table (seg_n -> bcd):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4.
  - 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
  - Any other pattern -> bcd 4'hF with the per-digit err bit set.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: digit_en is zero or not one-hot. Counter = 0. Go to SETTLE when digit_en becomes one-hot.
  - SETTLE: counter increments each cycle in which seg_n and digit_en both equal the previous sample. Any change reloads the counter to 0 and stays in SETTLE; a change to non-one-hot goes to IDLE.
  - Capture: when the counter reaches STABLE_CYCLES-1, the decoded value and err bit are written to the slot of the active digit. That mask bit is set. Go to HOLD.
  - HOLD: no recapture while digit_en is unchanged; seg_n changes are ignored. Any digit_en change leaves HOLD, to SETTLE if the new value is one-hot, otherwise to IDLE.
- Capture latency: STABLE_CYCLES cycles after the last input change.
- A digit captured twice before the frame completes overwrites its own slot.
- Frame completion:
  - Occurs when a capture makes the mask all ones.
  - If out_valid=0, or out_valid=1 with out_ready=1 in the same cycle: on the next edge, load out_bcd/out_err, set out_valid=1, clear the mask.
  - If out_valid=1 with out_ready=0: drop the new frame, clear the mask, set overrun=1. The presented frame is unchanged.
- Handshake:
  - out_bcd and out_err are stable while out_valid=1 and out_ready=0.
  - On a transfer with no simultaneous completion, out_valid goes to 0 on the next edge.
  - out_ready while out_valid=0 has no effect.
- overrun clears only on reset.
- Reset asserted mid-frame discards the partial mask and any presented frame.
- Counter width: $clog2(STABLE_CYCLES+1). The counter saturates and never wraps.

Optional Feature:
- Macro: SEG7_BLANK_EN.
- Defined: seg_n=1111111 (all segments off) is a valid blank digit. It decodes to 4'hA with err=0.
- Undefined: all-off is an invalid pattern (4'hF, err=1).

Test Plan:
- Reset release, then DIGITS=4, STABLE_CYCLES=4, strobes digits 0..3 showing 1,2,3,4, each held 8 cycles -> out_valid=1 one cycle after digit 3 capture; out_bcd=16'h4321; out_err=0.
- seg_n toggles every 2 cycles during a strobe, then settles on 0000100 -> no capture until 4 stable samples; digit value 9.
- Pattern 1111110 on digit 2 -> out_bcd[11:8]=4'hF; out_err=4'b0100.
- out_ready=0 through two complete frames -> first frame held unchanged; second dropped; overrun=1; after out_ready=1, out_valid=0 next cycle.
- digit_en=4'b0110 for 10 cycles -> no capture; mask unchanged.
- rst_n pulsed low mid-frame, asynchronous to clk -> all outputs 0 immediately; next full frame assembles from scratch.
- All-off pattern on a digit -> 4'hA with err=0 when SEG7_BLANK_EN is defined; 4'hF with err=1 when it is undefined.
